grf_multi: RTL and testbench
============================

Name: grf_multi

Overview:
- Parametrised successor of the single-cycle general register file, for the pipelined CPU.
- Provides N combinational read ports with optional same-cycle write-to-read bypass and one synchronous write port.
- Adds a per-register pending-write scoreboard that feeds hazard detection, and a registered writeback trace channel that replaces in-module $display logging.
- Sits between decode (reads, issue) and writeback (write) stages.

Parameters:
- DW, 32: data width.
- AW, 5: address width; depth = 2**AW; register 0 hardwired zero.
- NR, 2: number of read ports (1..4).
- BYPASS, 1: 1 means read data forwards same-cycle write data; 0 means reads return stored value.
- PW, 2: width of per-register pending counter (max outstanding writes = 2**PW-1).
- CW, 32: width of trace write counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rd_addr  in  NR*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NR*DW  read data, port k at [k*DW +: DW]
- rd_busy  out  NR  port k register has pending count != 0
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  DW  write data
- wpc  in  32  PC of writing instruction (trace only)
- iss_valid  in  1  decode issues an instruction that will write iss_addr
- iss_addr  in  AW  destination of issued instruction
- iss_ready  out  1  combinational; 0 when iss_addr counter is saturated
- trace_valid  out  1  registered write event
- trace_pc  out  32  PC of traced write
- trace_addr  out  AW  traced destination
- trace_data  out  DW  traced data
- trace_cnt  out  CW  index of traced write (0 for first)
- sb_err  out  1  sticky scoreboard error

Behaviour:
- Reset (async, any time, including mid-write): all registers 0, all pending counters 0, trace_valid 0, trace_pc/addr/data 0, trace_cnt 0, sb_err 0; internal write counter 0.
- Read: combinational. rd_data[k] = 0 if rd_addr[k]==0. Else if BYPASS && we && wa==rd_addr[k], then wd. Else stored value.
- Write: at posedge, if we && wa!=0, then reg[wa] <= wd. Writes to 0 are discarded: no storage change, no trace, no counter change.
- Trace: one cycle after an accepted write, trace_valid=1 with that write's wpc/wa/wd and trace_cnt = number of accepted writes before it. Internal counter then increments, wrapping at 2**CW. trace_valid=0 in cycles with no accepted write in the previous cycle. Other trace outputs hold their last value.
- Scoreboard, per register r != 0 (counter cnt[r]):
  - issue hit: iss_valid && iss_ready && iss_addr==r && r!=0
  - wb hit: we && wa==r
  - issue only: cnt+1
  - wb only: cnt>0 gives cnt-1; cnt==0 leaves cnt unchanged and sets sb_err
  - both same cycle: cnt unchanged, no error
- iss_ready = !(iss_addr!=0 && cnt[iss_addr]==2**PW-1 && !(we && wa==iss_addr)). A simultaneous writeback frees a slot.
- Issue to register 0 is always ready and has no effect.
- rd_busy[k] reflects the pre-edge counter. It is not cleared by a same-cycle writeback; with BYPASS the data is still correct.
- sb_err clears only on reset.

Decomposition:
- Shared package cpu_pkg: DW/AW defaults, REG_ZERO constant, trace record field widths.
- One sub-module, grf_scoreboard: pending counters, iss_ready, rd_busy, sb_err; parameters AW, NR, PW.
- Storage, bypass and trace stay in grf_multi.

Test Plan:
- Reset mid-operation: write reg5=0x1234 and issue reg5, then pulse reset between edges. Immediately: rd_data(5)=0, rd_busy=0, trace_valid=0, trace_cnt=0.
- Bypass: BYPASS=1, we=1, wa=7, wd=0xDEADBEEF, rd_addr0=7 in same cycle. rd_data0=0xDEADBEEF before the edge. With BYPASS=0 it returns the old 0 until after the edge.
- Register zero: we=1, wa=0, wd=0xFFFFFFFF. rd_data(0)=0, no trace_valid next cycle, trace_cnt unchanged.
- Trace sequence: writes reg1=0x11 @pc 0x3000, then reg2=0x22 @pc 0x3004 on consecutive cycles. Outputs are trace_valid=1, (0x3000,1,0x11,cnt 0), then (0x3004,2,0x22,cnt 1), then trace_valid=0.
- Scoreboard saturation (PW=2): issue reg3 three times, so rd_busy=1 and iss_ready=0 for reg3. Same-cycle issue+writeback of reg3 gives iss_ready=1 and the count stays 3. Three more writebacks bring the count to 0 and rd_busy=0.
- Underflow: writeback reg9 with count 0. sb_err=1 next cycle, reg9 is updated, sb_err persists until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU register-file slice.
// Holds default data/address widths, the hardwired-zero register index and
// the field widths used by the writeback trace record.
package cpu_pkg;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;
    localparam int TR_PC_W  = 32;
    localparam int TR_CNT_W = 32;
endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard for the general register file.
// Tracks outstanding writes per register, gates issue when a counter is full,
// reports per-read-port busy and a sticky underflow error.
// Ports:
//   clk, reset        clock, async active-high reset
//   i_rd_addr         packed read addresses (NR x AW)
//   o_rd_busy         per read port: addressed register has pending writes
//   i_we, i_wa        writeback enable / address
//   i_iss_valid/addr  issue of an instruction writing i_iss_addr
//   o_iss_ready       combinational issue acceptance
//   o_sb_err          sticky error: writeback with no pending write
module grf_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int NR = 2,
    parameter int PW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] i_rd_addr,
    output logic [NR-1:0]    o_rd_busy,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic             i_iss_valid,
    input  logic [AW-1:0]    i_iss_addr,
    output logic             o_iss_ready,
    output logic             o_sb_err
);
    localparam int DEPTH = 2**AW;
    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);

    logic [PW-1:0]    r_cnt [DEPTH];
    logic [DEPTH-1:0] w_iss_hit;
    logic [DEPTH-1:0] w_wb_hit;
    logic             w_underflow;

    always_comb begin
        // a writeback to the same register this cycle frees a slot
        o_iss_ready = !((i_iss_addr != ZERO_A) && (r_cnt[i_iss_addr] == CNT_MAX)
                        && !(i_we && (i_wa == i_iss_addr)));
        w_iss_hit = '0;
        w_wb_hit  = '0;
        if (i_iss_valid && o_iss_ready && (i_iss_addr != ZERO_A))
            w_iss_hit[i_iss_addr] = 1'b1;
        if (i_we && (i_wa != ZERO_A))
            w_wb_hit[i_wa] = 1'b1;
        w_underflow = 1'b0;
        for (int r = 0; r < DEPTH; r++)
            if (w_wb_hit[r] && !w_iss_hit[r] && (r_cnt[r] == '0))
                w_underflow = 1'b1;
        for (int k = 0; k < NR; k++)
            o_rd_busy[k] = (r_cnt[i_rd_addr[k*AW +: AW]] != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++)
                r_cnt[r] <= '0;
            o_sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_iss_hit[r] && !w_wb_hit[r])
                    r_cnt[r] <= r_cnt[r] + PW'(1);
                else if (w_wb_hit[r] && !w_iss_hit[r] && (r_cnt[r] != '0))
                    r_cnt[r] <= r_cnt[r] - PW'(1);
            end
            if (w_underflow)
                o_sb_err <= 1'b1;
        end
    end
endmodule

// File: rtl/grf_multi.sv
// Multi-port general register file for the pipelined CPU.
// NR combinational read ports with optional same-cycle write bypass, one
// synchronous write port, pending-write scoreboard and a registered
// writeback trace channel. Register 0 reads as zero and ignores writes.
// Ports:
//   clk, reset               clock, async active-high reset
//   rd_addr / rd_data        packed read addresses / data
//   rd_busy                  per read port pending-write flag
//   we, wa, wd, wpc          write port and PC of the writing instruction
//   iss_valid, iss_addr      issue of an instruction writing iss_addr
//   iss_ready                combinational issue acceptance
//   trace_*                  one-cycle-delayed record of each accepted write
//   sb_err                   sticky scoreboard underflow
module grf_multi
    import cpu_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NR     = 2,
    parameter int BYPASS = 1,
    parameter int PW     = 2,
    parameter int CW     = TR_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR*DW-1:0]   rd_data,
    output logic [NR-1:0]      rd_busy,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [DW-1:0]      wd,
    input  logic [TR_PC_W-1:0] wpc,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    output logic               iss_ready,
    output logic               trace_valid,
    output logic [TR_PC_W-1:0] trace_pc,
    output logic [AW-1:0]      trace_addr,
    output logic [DW-1:0]      trace_data,
    output logic [CW-1:0]      trace_cnt,
    output logic               sb_err
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DW-1:0]      r_regs [DEPTH];
    logic               r_trace_valid;
    logic [TR_PC_W-1:0] r_trace_pc;
    logic [AW-1:0]      r_trace_addr;
    logic [DW-1:0]      r_trace_data;
    logic [CW-1:0]      r_trace_cnt;
    logic [CW-1:0]      r_wcnt;
    logic               w_wr_acc;

    assign w_wr_acc = we && (wa != ZERO_A);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] ra;
            ra = rd_addr[k*AW +: AW];
            if (ra == ZERO_A)
                rd_data[k*DW +: DW] = '0;
            else if ((BYPASS != 0) && we && (wa == ra))
                rd_data[k*DW +: DW] = wd;
            else
                rd_data[k*DW +: DW] = r_regs[ra];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++)
                r_regs[r] <= '0;
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
            r_trace_cnt   <= '0;
            r_wcnt        <= '0;
        end else begin
            r_trace_valid <= w_wr_acc;
            if (w_wr_acc) begin
                r_regs[wa]   <= wd;
                r_trace_pc   <= wpc;
                r_trace_addr <= wa;
                r_trace_data <= wd;
                r_trace_cnt  <= r_wcnt;
                r_wcnt       <= r_wcnt + CW'(1);
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign trace_cnt   = r_trace_cnt;

    grf_scoreboard #(
        .AW (AW),
        .NR (NR),
        .PW (PW)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_rd_addr   (rd_addr),
        .o_rd_busy   (rd_busy),
        .i_we        (we),
        .i_wa        (wa),
        .i_iss_valid (iss_valid),
        .i_iss_addr  (iss_addr),
        .o_iss_ready (iss_ready),
        .o_sb_err    (sb_err)
    );
endmodule

// File: tb/tb_grf_multi.sv
// Directed bench for grf_multi: one bypassing and one non-bypassing instance
// share the same stimulus.
module tb_grf_multi;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int PW = 2;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [31:0]      wpc;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;

    logic [NR*DW-1:0] u0_rd_data, u1_rd_data;
    logic [NR-1:0]    u0_rd_busy, u1_rd_busy;
    logic             u0_iss_ready, u1_iss_ready;
    logic             u0_tv, u1_tv;
    logic [31:0]      u0_tpc, u1_tpc;
    logic [AW-1:0]    u0_ta, u1_ta;
    logic [DW-1:0]    u0_td, u1_td;
    logic [CW-1:0]    u0_tc, u1_tc;
    logic             u0_err, u1_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_multi #(.DW(DW), .AW(AW), .NR(NR), .BYPASS(1), .PW(PW), .CW(CW)) u0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(u0_rd_data),
        .rd_busy(u0_rd_busy), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(u0_iss_ready),
        .trace_valid(u0_tv), .trace_pc(u0_tpc), .trace_addr(u0_ta),
        .trace_data(u0_td), .trace_cnt(u0_tc), .sb_err(u0_err)
    );

    grf_multi #(.DW(DW), .AW(AW), .NR(NR), .BYPASS(0), .PW(PW), .CW(CW)) u1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(u1_rd_data),
        .rd_busy(u1_rd_busy), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(u1_iss_ready),
        .trace_valid(u1_tv), .trace_pc(u1_tpc), .trace_addr(u1_ta),
        .trace_data(u1_td), .trace_cnt(u1_tc), .sb_err(u1_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        wpc       = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    task automatic check_trace(input string tag, input logic v, input logic [31:0] pc,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [CW-1:0] c);
        check({tag, ".valid"}, 64'(u0_tv), 64'(v));
        check({tag, ".pc"},    64'(u0_tpc), 64'(pc));
        check({tag, ".addr"},  64'(u0_ta), 64'(a));
        check({tag, ".data"},  64'(u0_td), 64'(d));
        check({tag, ".cnt"},   64'(u0_tc), 64'(c));
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        repeat (2) step();

        // reset state
        rd_addr = {5'd2, 5'd1};
        #1;
        check("rst.rd0", 64'(u0_rd_data[31:0]), 64'd0);
        check("rst.rd1", 64'(u0_rd_data[63:32]), 64'd0);
        check("rst.busy", 64'(u0_rd_busy), 64'd0);
        check("rst.ready", 64'(u0_iss_ready), 64'd1);
        check("rst.err", 64'(u0_err), 64'd0);
        check_trace("rst.tr", 1'b0, 32'h0, 5'd0, 32'h0, 32'd0);
        reset = 1'b0;
        step();

        // bypass: write reg7 with a same-cycle issue so the scoreboard stays clean
        we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; wpc = 32'h100;
        iss_valid = 1'b1; iss_addr = 5'd7;
        rd_addr = {5'd0, 5'd7};
        #1;
        check("byp.pre.u0", 64'(u0_rd_data[31:0]), 64'hDEADBEEF);
        check("byp.pre.u1", 64'(u1_rd_data[31:0]), 64'd0);
        check("byp.pre.rd1zero", 64'(u0_rd_data[63:32]), 64'd0);
        step();
        idle();
        #1;
        check("byp.post.u0", 64'(u0_rd_data[31:0]), 64'hDEADBEEF);
        check("byp.post.u1", 64'(u1_rd_data[31:0]), 64'hDEADBEEF);
        check_trace("byp.tr", 1'b1, 32'h100, 5'd7, 32'hDEADBEEF, 32'd0);
        check("byp.err", 64'(u0_err), 64'd0);

        // register zero write is dropped
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wpc = 32'h200;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("r0.pre", 64'(u0_rd_data[31:0]), 64'd0);
        step();
        idle();
        #1;
        check("r0.rd", 64'(u0_rd_data[31:0]), 64'd0);
        check_trace("r0.tr", 1'b0, 32'h100, 5'd7, 32'hDEADBEEF, 32'd0);
        check("r0.err", 64'(u0_err), 64'd0);

        // fresh start for the trace sequence
        reset = 1'b1; #2; reset = 1'b0;
        we = 1'b1; wa = 5'd1; wd = 32'h11; wpc = 32'h3000;
        iss_valid = 1'b1; iss_addr = 5'd1;
        step();
        check_trace("tr.w1", 1'b1, 32'h3000, 5'd1, 32'h11, 32'd0);
        wa = 5'd2; wd = 32'h22; wpc = 32'h3004; iss_addr = 5'd2;
        step();
        check_trace("tr.w2", 1'b1, 32'h3004, 5'd2, 32'h22, 32'd1);
        idle();
        step();
        check_trace("tr.idle", 1'b0, 32'h3004, 5'd2, 32'h22, 32'd1);
        rd_addr = {5'd2, 5'd1};
        #1;
        check("tr.rd1", 64'(u0_rd_data[31:0]), 64'h11);
        check("tr.rd2", 64'(u0_rd_data[63:32]), 64'h22);
        check("tr.err", 64'(u0_err), 64'd0);

        // scoreboard saturation on reg3
        rd_addr = {5'd0, 5'd3};
        iss_valid = 1'b1; iss_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sat.ready%0d", i), 64'(u0_iss_ready), 64'd1);
            step();
        end
        check("sat.busy", 64'(u0_rd_busy[0]), 64'd1);
        check("sat.full", 64'(u0_iss_ready), 64'd0);
        step();  // rejected issue must not count
        check("sat.full2", 64'(u0_iss_ready), 64'd0);
        we = 1'b1; wa = 5'd3; wd = 32'h33; wpc = 32'h4000;
        #1;
        check("sat.wbfree", 64'(u0_iss_ready), 64'd1);
        check("sat.busywb", 64'(u0_rd_busy[0]), 64'd1);
        step();
        we = 1'b0;
        #1;
        check("sat.stay3", 64'(u0_iss_ready), 64'd0);
        check("sat.err0", 64'(u0_err), 64'd0);
        iss_valid = 1'b0;
        we = 1'b1; wa = 5'd3; wd = 32'h34;
        step();
        check("sat.cnt2.ready", 64'(u0_iss_ready), 64'd1);
        check("sat.cnt2.busy", 64'(u0_rd_busy[0]), 64'd1);
        repeat (2) step();
        idle();
        iss_addr = 5'd3;
        #1;
        check("sat.cnt0.busy", 64'(u0_rd_busy[0]), 64'd0);
        check("sat.cnt0.err", 64'(u0_err), 64'd0);
        check("sat.rd3", 64'(u0_rd_data[31:0]), 64'h34);
        check("sat.tr.cnt", 64'(u0_tc), 64'd5);

        // underflow on reg9
        we = 1'b1; wa = 5'd9; wd = 32'h99; wpc = 32'h5000;
        rd_addr = {5'd0, 5'd9};
        #1;
        check("uf.pre", 64'(u0_err), 64'd0);
        step();
        idle();
        #1;
        check("uf.err", 64'(u0_err), 64'd1);
        check("uf.rd9", 64'(u1_rd_data[31:0]), 64'h99);
        repeat (3) step();
        check("uf.sticky", 64'(u0_err), 64'd1);

        // reset in the middle of activity on reg5
        iss_valid = 1'b1; iss_addr = 5'd5;
        repeat (2) step();
        iss_valid = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 32'h1234; wpc = 32'h6000;
        rd_addr = {5'd0, 5'd5};
        step();
        idle();
        #1;
        check("mid.pre.rd5", 64'(u0_rd_data[31:0]), 64'h1234);
        check("mid.pre.busy", 64'(u0_rd_busy[0]), 64'd1);
        check_trace("mid.pre.tr", 1'b1, 32'h6000, 5'd5, 32'h1234, 32'd7);
        reset = 1'b1;
        #1;
        check("mid.rd5", 64'(u0_rd_data[31:0]), 64'd0);
        check("mid.busy", 64'(u0_rd_busy[0]), 64'd0);
        check("mid.err", 64'(u0_err), 64'd0);
        check_trace("mid.tr", 1'b0, 32'h0, 5'd0, 32'h0, 32'd0);
        check("mid.u1.rd5", 64'(u1_rd_data[31:0]), 64'd0);
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
